// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM
// for the RV32I core, with a shared memory port, instret counter and watchdog.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_req/we/addr_sel shared memory port request (addr_sel 0=PC, 1=ALU)
//   mem_ready           memory accepts/completes the request this cycle
//   dec_*               decoded instruction class; cmp_taken branch result
//   ir_load, pc_write   IR capture and PC update enables
//   pc_sel              0=PC+4, 1=ALU target
//   reg_write, wb_sel   regfile enable; wb mux 0=ALU 1=load 2=PC+4
//   state               FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WRITEBACK=4 HALT=5
//   halted, bus_error   sticky stop flags, cleared only by rst
//   instret             retired instruction count (wraps)
module core_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  input  logic             mem_ready,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_system,
  input  logic             cmp_taken,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam int WD_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic            l_read;
  logic            l_write;
  logic            l_branch;
  logic            l_jump;
  logic            l_taken;
  logic            berr;
  logic [CNT_W-1:0] cnt;
  logic [WD_W-1:0] wd;
  logic            wait_c;
  logic            expire;

  assign wait_c = mem_req && !mem_ready;

  // Expiry is judged on the last allowed wait cycle; a
  // mem_ready in that cycle clears wait_c and so wins.
  assign expire = (MEM_TIMEOUT != 0) && wait_c &&
                  (wd == WD_W'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH: begin
        if (mem_ready)   nxt = S_DECODE;
        else if (expire) nxt = S_HALT;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (dec_system)
          nxt = S_HALT;
        else if (dec_mem_read || dec_mem_write)
          nxt = S_MEM;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready)   nxt = S_WB;
        else if (expire) nxt = S_HALT;
      end
      S_WB:    nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

  // Every output is forced low while rst is held,
  // whatever state the register still holds.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    if (!rst) begin
      unique case (cur)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_we       = l_write;
          mem_addr_sel = 1'b1;
        end
        S_WB: begin
          pc_write  = 1'b1;
          pc_sel    = l_jump | (l_branch & l_taken);
          reg_write = ~(l_write | l_branch);
          unique case (1'b1)
            l_read:  wb_sel = 2'd1;
            l_jump:  wb_sel = 2'd2;
            default: wb_sel = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state     = rst ? 3'd0 : cur;
  assign halted    = !rst && (cur == S_HALT);
  assign bus_error = !rst && berr;
  assign instret   = rst ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_FETCH;
      cnt      <= '0;
      berr     <= 1'b0;
      wd       <= '0;
      l_read   <= 1'b0;
      l_write  <= 1'b0;
      l_branch <= 1'b0;
      l_jump   <= 1'b0;
      l_taken  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_EXEC) begin
        // read+write together is treated as a store
        l_read   <= dec_mem_read & ~dec_mem_write;
        l_write  <= dec_mem_write;
        l_branch <= dec_branch;
        l_jump   <= dec_jump;
        l_taken  <= cmp_taken;
      end
      if (cur == S_WB)
        cnt <= cnt + 1'b1;
      if (expire)
        berr <= 1'b1;
      if (wait_c && !expire && nxt == cur)
        wd <= wd + 1'b1;
      else
        wd <= '0;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer.
// Expected per-cycle output vectors are queued as stimulus is driven.
module tb_core_sequencer;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       mem_ready;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_system;
  logic       cmp_taken;
  logic       ir_load;
  logic       pc_write;
  logic       pc_sel;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic [2:0] state;
  logic       halted;
  logic       bus_error;
  logic [3:0] instret;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  m_instret;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  localparam logic [4:0] D_ALU   = 5'b00000;
  localparam logic [4:0] D_LOAD  = 5'b10000;
  localparam logic [4:0] D_STORE = 5'b01000;
  localparam logic [4:0] D_BR    = 5'b00100;
  localparam logic [4:0] D_JAL   = 5'b00010;
  localparam logic [4:0] D_SYS   = 5'b00001;

  core_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel),
    .mem_ready(mem_ready),
    .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_branch(dec_branch),
    .dec_jump(dec_jump),
    .dec_system(dec_system),
    .cmp_taken(cmp_taken),
    .ir_load(ir_load),
    .pc_write(pc_write),
    .pc_sel(pc_sel),
    .reg_write(reg_write),
    .wb_sel(wb_sel),
    .state(state),
    .halted(halted),
    .bus_error(bus_error),
    .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(
    input logic [2:0] st, input logic rq,
    input logic we, input logic as,
    input logic irl, input logic pw,
    input logic ps, input logic rw,
    input logic [1:0] wb, input logic h,
    input logic be);
    return {st, rq, we, as, irl, pw, ps, rw,
            wb, h, be, m_instret};
  endfunction

  // One clock: apply inputs, sample at negedge, queue expected.
  task automatic cyc(input logic rdy, input logic [4:0] d,
                     input logic tk, input logic [17:0] e);
    mem_ready = rdy;
    {dec_mem_read, dec_mem_write, dec_branch,
     dec_jump, dec_system} = d;
    cmp_taken = tk;
    @(negedge clk);
    obs_q.push_back({state, mem_req, mem_we, mem_addr_sel,
                     ir_load, pc_write, pc_sel, reg_write,
                     wb_sel, halted, bus_error, instret});
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 5'b11111, 1'b1, 18'h0);
    rst = 1'b0;
    m_instret = 4'd0;
  endtask

  // Reference sequence of one instruction with given wait counts.
  task automatic do_instr(input logic [4:0] d, input int fw,
                          input int mw, input logic tk);
    logic ld, st, br, jp, sy, ps, rw;
    logic [1:0] wb;
    ld = d[4] & ~d[3];
    st = d[3];
    br = d[2];
    jp = d[1];
    sy = d[0];
    for (int i = 0; i < fw; i++)
      cyc(1'b0, 5'b0, 1'b0, mk(3'd0,1,0,0,0,0,0,0,2'd0,0,0));
    cyc(1'b1, 5'b0, 1'b0, mk(3'd0,1,0,0,1,0,0,0,2'd0,0,0));
    cyc(1'b0, d, tk, mk(3'd1,0,0,0,0,0,0,0,2'd0,0,0));
    cyc(1'b0, d, tk, mk(3'd2,0,0,0,0,0,0,0,2'd0,0,0));
    if (sy) begin
      repeat (2)
        cyc(1'b1, 5'b0, 1'b0, mk(3'd5,0,0,0,0,0,0,0,2'd0,1,0));
      return;
    end
    if (ld | st) begin
      for (int i = 0; i < mw; i++)
        cyc(1'b0, 5'b0, 1'b0, mk(3'd3,1,st,1,0,0,0,0,2'd0,0,0));
      cyc(1'b1, 5'b0, 1'b0, mk(3'd3,1,st,1,0,0,0,0,2'd0,0,0));
    end
    ps = jp | (br & tk);
    rw = ~(st | br);
    wb = ld ? 2'd1 : (jp ? 2'd2 : 2'd0);
    cyc(1'b0, 5'b0, 1'b0, mk(3'd4,0,0,0,0,1,ps,rw,wb,0,0));
    m_instret = m_instret + 4'd1;
  endtask

  task automatic test_reset();
    int k = 0;
    do_reset();
    rst = 1'b1;
    cyc(1'b1, 5'b0, 1'b0, 18'h0);
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_addi();
    int k = 0;
    do_instr(D_ALU, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL addi c%0d got %h want %h", k, o, e);
      end
      k++;
    end
    n_chk++;
    if (instret !== 4'd1) begin
      n_fail++;
      $display("FAIL addi_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_lw_sw();
    int k = 0;
    do_instr(D_LOAD, 2, 3, 1'b0);
    do_instr(D_STORE, 0, 0, 1'b1);
    do_instr(D_STORE, 1, 2, 1'b0);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lw_sw c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_branch_jump();
    int k = 0;
    do_instr(D_BR, 0, 0, 1'b1);
    do_instr(D_BR, 0, 0, 1'b0);
    do_instr(D_JAL, 0, 0, 1'b0);
    do_instr(D_JAL, 1, 0, 1'b1);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL brj c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    do_instr(D_ALU, 0, 0, 1'b0);
    do_instr(5'b11000, 0, 1, 1'b0);
    do_instr(D_LOAD, 0, 0, 1'b0);
    do_instr(D_BR, 2, 0, 1'b1);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_rst_mid();
    int k = 0;
    cyc(1'b1, 5'b0, 1'b0, mk(3'd0,1,0,0,1,0,0,0,2'd0,0,0));
    cyc(1'b0, D_LOAD, 1'b0, mk(3'd1,0,0,0,0,0,0,0,2'd0,0,0));
    cyc(1'b0, D_LOAD, 1'b0, mk(3'd2,0,0,0,0,0,0,0,2'd0,0,0));
    cyc(1'b0, 5'b0, 1'b0, mk(3'd3,1,0,1,0,0,0,0,2'd0,0,0));
    rst = 1'b1;
    cyc(1'b1, 5'b0, 1'b0, 18'h0);
    rst = 1'b0;
    m_instret = 4'd0;
    do_instr(D_ALU, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rst_mid c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_watchdog();
    int k = 0;
    do_reset();
    repeat (4)
      cyc(1'b0, 5'b0, 1'b0, mk(3'd0,1,0,0,0,0,0,0,2'd0,0,0));
    repeat (2)
      cyc(1'b1, 5'b0, 1'b0, mk(3'd5,0,0,0,0,0,0,0,2'd0,1,1));
    do_reset();
    do_instr(D_ALU, 3, 0, 1'b0);
    do_instr(D_STORE, 0, 3, 1'b0);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL watchdog c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_ecall();
    int k = 0;
    do_instr(D_ALU, 0, 0, 1'b0);
    do_instr(D_SYS, 0, 0, 1'b0);
    do_reset();
    do_instr(D_ALU, 0, 0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ecall c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    do_reset();
    repeat (16) do_instr(D_ALU, 0, 0, 1'b0);
    n_chk++;
    if (instret !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_instret got %0d want 0", instret);
    end
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap c%0d got %h want %h", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b0;
    dec_mem_read = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch = 1'b0;
    dec_jump = 1'b0;
    dec_system = 1'b0;
    cmp_taken = 1'b0;
    m_instret = 4'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_lw_sw();
    test_branch_jump();
    test_back_to_back();
    test_rst_mid();
    test_watchdog();
    test_ecall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
